// File: rtl/round_share_arb.sv
// Round-robin sharing of one fixed-latency round unit among N requesters, with a tag pipe
// that steers each result back to its owner. Define ROUND_SHARE_ARB_LAT_CHK_EN to add lat_err.
module round_share_arb #(
    parameter int N       = 4,
    parameter int W_IN    = 33,
    parameter int W_OUT   = 32,
    parameter int RND_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [N-1:0]        req_vld,
    input  logic [N*W_IN-1:0]   req_data,
    output logic [N-1:0]        req_rdy,
    output logic [W_IN-1:0]     rnd_i_data,
    output logic                rnd_i_vld,
    input  logic [W_OUT-1:0]    rnd_o_data,
    input  logic                rnd_o_vld,
    output logic [W_OUT-1:0]    rsp_data,
    output logic [N-1:0]        rsp_vld,
    output logic                busy
`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
    ,
    output logic                lat_err
`endif
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0]   ptr_r;
    logic             grant_found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW:0]     idx_s;
    logic [N-1:0]     grant_oh_s;
    logic             hs_s;

    logic [W_IN-1:0]  rnd_i_data_r;
    logic             rnd_i_vld_r;
    logic [IDW-1:0]   issue_id_r;

    logic [RND_LAT-1:0] tag_vld_r;
    logic [RND_LAT-1:0] tag_vld_nxt_s;
    logic [IDW-1:0]     tag_id_r     [RND_LAT];
    logic [IDW-1:0]     tag_id_nxt_s [RND_LAT];

    logic             rsp_fire_s;
    logic [W_OUT-1:0] rsp_data_r;
    logic [N-1:0]     rsp_vld_r;
    logic             busy_r;

    // Round-robin search starting at ptr_r, wrapping modulo N.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        idx_s         = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(N)) begin
                idx_s = idx_s - (IDW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_found_s && req_vld[idx_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept for the winner, suppressed while holding.
    always_comb begin
        grant_oh_s = '0;
        hs_s       = grant_found_s & ~hold;
        if (hs_s) begin
            grant_oh_s[grant_id_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Next contents of the tag shift register; stage 0 takes the sample issued this cycle.
    always_comb begin
        tag_vld_nxt_s    = '0;
        tag_vld_nxt_s[0] = rnd_i_vld_r;
        tag_id_nxt_s[0]  = issue_id_r;
        for (int k = 1; k < RND_LAT; k++) begin
            tag_vld_nxt_s[k] = tag_vld_r[k-1];
            tag_id_nxt_s[k]  = tag_id_r[k-1];
        end
    end

    assign rsp_fire_s = rnd_o_vld & tag_vld_r[RND_LAT-1];

    // Pointer, issue register and tag pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r        <= '0;
            rnd_i_vld_r  <= 1'b0;
            rnd_i_data_r <= '0;
            issue_id_r   <= '0;
            tag_vld_r    <= '0;
            tag_id_r     <= '{default: '0};
        end else begin
            rnd_i_vld_r <= hs_s;
            tag_vld_r   <= tag_vld_nxt_s;
            tag_id_r    <= tag_id_nxt_s;
            if (hs_s) begin
                ptr_r        <= (grant_id_s == IDW'(N-1)) ? '0 : grant_id_s + IDW'(1);
                rnd_i_data_r <= req_data[grant_id_s*W_IN +: W_IN];
                issue_id_r   <= grant_id_s;
            end
        end
    end

    // Response steering; busy covers issue, tag pipe and the pending response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_r  <= '0;
            rsp_data_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            rsp_vld_r <= '0;
            busy_r    <= hs_s | (|tag_vld_nxt_s) | rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_vld_r[tag_id_r[RND_LAT-1]] <= 1'b1;
                rsp_data_r                     <= rnd_o_data;
            end
        end
    end

    assign req_rdy    = grant_oh_s;
    assign rnd_i_data = rnd_i_data_r;
    assign rnd_i_vld  = rnd_i_vld_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_vld    = rsp_vld_r;
    assign busy       = busy_r;

`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
    logic lat_err_r;

    // Sticky flag for any cycle where the round unit's valid disagrees with the tail tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_err_r <= 1'b0;
        end else if (rnd_o_vld != tag_vld_r[RND_LAT-1]) begin
            lat_err_r <= 1'b1;
            $error("round_share_arb: latency mismatch at time %0t", $time);
        end
    end

    assign lat_err = lat_err_r;
`endif

endmodule

// File: tb/tb_round_share_arb.sv
// Self-checking bench for round_share_arb: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_round_share_arb;

    localparam int N       = 4;
    localparam int W_IN    = 33;
    localparam int W_OUT   = 32;
    localparam int RND_LAT = 2;
    localparam int SH      = W_IN - W_OUT;
    localparam int RSP_LAT = RND_LAT + 2;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [N-1:0]      req_vld;
    logic [N*W_IN-1:0] req_data;
    logic [N-1:0]      req_rdy;
    logic [W_IN-1:0]   rnd_i_data;
    logic              rnd_i_vld;
    logic [W_OUT-1:0]  rnd_o_data;
    logic              rnd_o_vld;
    logic [W_OUT-1:0]  rsp_data;
    logic [N-1:0]      rsp_vld;
    logic              busy;
`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
    logic              lat_err;
`endif

    round_share_arb #(.N(N), .W_IN(W_IN), .W_OUT(W_OUT), .RND_LAT(RND_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req_vld    (req_vld),
        .req_data   (req_data),
        .req_rdy    (req_rdy),
        .rnd_i_data (rnd_i_data),
        .rnd_i_vld  (rnd_i_vld),
        .rnd_o_data (rnd_o_data),
        .rnd_o_vld  (rnd_o_vld),
        .rsp_data   (rsp_data),
        .rsp_vld    (rsp_vld),
`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
        .lat_err    (lat_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic shift right by SH with round-half-up.
    function automatic logic [W_OUT-1:0] rnd_f(input logic [W_IN-1:0] x);
        logic [W_IN:0] t;
        t = {x[W_IN-1], x} + ((W_IN+1)'(1) << (SH - 1));
        return t[SH +: W_OUT];
    endfunction

    // Stand-in round unit, two-cycle latency, plus a stray-valid injector.
    logic             s1_vld, o_vld_q, inject;
    logic [W_OUT-1:0] s1_d, o_d_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0; s1_d <= '0; o_vld_q <= 1'b0; o_d_q <= '0;
        end else begin
            s1_vld <= rnd_i_vld; s1_d <= rnd_f(rnd_i_data);
            o_vld_q <= s1_vld;   o_d_q <= s1_d;
        end
    end
    assign rnd_o_vld  = o_vld_q | inject;
    assign rnd_o_data = o_d_q;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Reference model: every accepted sample is remembered with the cycle it was granted.
    typedef struct {
        int              id;
        logic [W_IN-1:0] d;
        int              issue;
    } ent_t;
    ent_t             q[$];
    int               ptr_m;
    logic [W_IN-1:0]  last_idata;
    logic [W_OUT-1:0] last_rd;

    task automatic model_clear();
        q.delete();
        ptr_m      = 0;
        last_idata = '0;
        last_rd    = '0;
    endtask

    task automatic cyc_m(input logic [N-1:0] v, input logic [N*W_IN-1:0] d, input logic h);
        int               g;
        logic [N-1:0]     e_rdy, e_rv;
        logic             e_ivld, e_busy;
        logic [W_IN-1:0]  e_idata;
        logic [W_OUT-1:0] e_rd;
        req_vld = v; req_data = d; hold = h;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (g < 0 && v[i]) g = i;
        end
        e_rdy = (h || g < 0) ? '0 : (N'(1) << g);
        chk("req_rdy", req_rdy, e_rdy);
        if (!h && g >= 0) begin
            q.push_back('{g, d[g*W_IN +: W_IN], cyc});
            ptr_m = (g + 1) % N;
        end
        tick();
        e_ivld = 1'b0; e_idata = last_idata; e_rv = '0; e_rd = last_rd; e_busy = 1'b0;
        foreach (q[j]) begin
            if (q[j].issue == cyc - 1) begin e_ivld = 1'b1; e_idata = q[j].d; end
            if (q[j].issue == cyc - RSP_LAT) begin e_rv = N'(1) << q[j].id; e_rd = rnd_f(q[j].d); end
            if (q[j].issue < cyc && cyc <= q[j].issue + RSP_LAT) e_busy = 1'b1;
        end
        chk("rnd_i_vld", rnd_i_vld, e_ivld);
        chk("rnd_i_data", rnd_i_data, e_idata);
        chk("rsp_vld", rsp_vld, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("busy", busy, e_busy);
        last_idata = e_idata;
        last_rd    = e_rd;
        while (q.size() > 0 && q[0].issue + RSP_LAT <= cyc) void'(q.pop_front());
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        int         p;
        logic       h;
        logic [3:0] v;
        logic [3:0] rdy;
    } gvec_t;
    gvec_t gt[8];

    logic [N*W_IN-1:0] dall;
    logic [63:0]       r64;

    initial begin
        gt[0] = '{0, 1'b0, 4'b0000, 4'b0000};
        gt[1] = '{0, 1'b0, 4'b1111, 4'b0001};
        gt[2] = '{2, 1'b0, 4'b1011, 4'b1000};
        gt[3] = '{3, 1'b0, 4'b1011, 4'b1000};
        gt[4] = '{1, 1'b0, 4'b1001, 4'b1000};
        gt[5] = '{3, 1'b0, 4'b0110, 4'b0010};
        gt[6] = '{2, 1'b1, 4'b1111, 4'b0000};
        gt[7] = '{1, 1'b0, 4'b0001, 4'b0001};

        rst = 1'b1; hold = 1'b0; req_vld = '0; req_data = '0; inject = 1'b0;
        model_clear();
        #3;
        chk("reset rnd_i_vld", rnd_i_vld, 1'b0);
        chk("reset rnd_i_data", rnd_i_data, '0);
        chk("reset rsp_vld", rsp_vld, '0);
        chk("reset rsp_data", rsp_data, '0);
        chk("reset busy", busy, 1'b0);
`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
        chk("reset lat_err", lat_err, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request from requester 1
        req_vld = 4'b0010;
        req_data[1*W_IN +: W_IN] = 33'd65535;
        #1 chk("single rdy", req_rdy, 4'b0010);
        tick();
        req_vld = '0;
        chk("single ivld", rnd_i_vld, 1'b1);
        chk("single idata", rnd_i_data, 33'd65535);
        chk("single busy+1", busy, 1'b1);
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk("single busy", busy, (j <= 4) ? 1'b1 : 1'b0);
            chk("single rsp_vld", rsp_vld, (j == 4) ? 4'b0010 : 4'b0000);
            if (j == 4) chk("single rsp_data", rsp_data, 32'd32768);
        end

        // Grant table: preset the pointer by a lone handshake from p-1, then probe.
        for (int t = 0; t < 8; t++) begin
            hold = 1'b0;
            req_vld = 4'b0001 << ((gt[t].p + N - 1) % N);
            tick();
            req_vld = gt[t].v; hold = gt[t].h;
            #1 chk($sformatf("grant_tbl[%0d]", t), req_rdy, gt[t].rdy);
        end
        req_vld = '0; hold = 1'b0;
        do_reset();

        // All four requesting continuously
        dall = {33'h400, 33'h300, 33'h200, 33'h100};
        for (int k = 0; k < 8; k++) begin
            req_vld = 4'b1111; req_data = dall; hold = 1'b0;
            #1 chk("rr order", req_rdy, 4'b0001 << (k % 4));
            cyc_m(4'b1111, dall, 1'b0);
        end
        repeat (5) cyc_m('0, dall, 1'b0);

        // Hold after two issues
        cyc_m(4'b1111, dall, 1'b0);
        cyc_m(4'b1111, dall, 1'b0);
        repeat (6) cyc_m(4'b1111, dall, 1'b1);
        chk("hold busy end", busy, 1'b0);
        cyc_m('0, dall, 1'b0);

        // Reset one cycle after an issue
        cyc_m(4'b0100, dall, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst rnd_i_vld", rnd_i_vld, 1'b0);
        chk("midrst rnd_i_data", rnd_i_data, '0);
        chk("midrst rsp_vld", rsp_vld, '0);
        chk("midrst rsp_data", rsp_data, '0);
        chk("midrst busy", busy, 1'b0);
        #2 rst = 1'b0;
        model_clear();
        repeat (6) cyc_m('0, dall, 1'b0);

        // Stray round-unit valid with no tag in flight
        inject = 1'b1;
        cyc_m('0, dall, 1'b0);
        inject = 1'b0;
        cyc_m('0, dall, 1'b0);
`ifdef ROUND_SHARE_ARB_LAT_CHK_EN
        chk("lat_err set", lat_err, 1'b1);
        repeat (3) cyc_m('0, dall, 1'b0);
        chk("lat_err sticky", lat_err, 1'b1);
        do_reset();
        chk("lat_err cleared", lat_err, 1'b0);
`endif

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                r64 = {$urandom(), $urandom()};
                dall[i*W_IN +: W_IN] = r64[W_IN-1:0];
            end
            cyc_m(N'($urandom_range(0, 15)), dall, ($urandom_range(0, 4) == 0));
        end
        repeat (6) cyc_m('0, dall, 1'b0);
        chk("final busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/round_share_arb.md
Name: round_share_arb

Overview:
- Shares one `round` instance (W_IN→W_OUT, fixed latency, no backpressure) between N requesters in the AC_PH postprocess cascade, e.g. the amplitude and phase paths.
- Arbitrates issue slots round-robin and drives the shared unit's i_data/i_vld.
- Tracks the requester ID of every in-flight sample in a tag pipe.
- Steers each rounded result back to its requester as a one-cycle valid pulse.

Parameters:
- N, 4, number of requesters (2..8)
- W_IN, 33, input sample width (signed)
- W_OUT, 32, rounded output width (signed)
- RND_LAT, 2, cycles from rnd_i_vld to rnd_o_vld of the shared round unit (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- hold  in  1  1 = issue no new grants; in-flight results still return
- req_vld  in  N  per-requester sample valid
- req_data  in  N*W_IN  per-requester signed sample; slice i = [i*W_IN +: W_IN]
- req_rdy  out  N  per-requester accept; a transfer occurs on req_vld[i] & req_rdy[i]
- rnd_i_data  out  W_IN  to round.i_data
- rnd_i_vld  out  1  to round.i_vld
- rnd_o_data  in  W_OUT  from round.o_data
- rnd_o_vld  in  1  from round.o_vld
- rsp_data  out  W_OUT  rounded result, shared by all requesters
- rsp_vld  out  N  one-hot result pulse for the owning requester
- busy  out  1  1 while any sample is in flight (tag pipe non-empty or rsp_vld pending)

Behaviour:
- Reset (async, rst=1): rnd_i_data=0, rnd_i_vld=0, rsp_data=0, rsp_vld=0, busy=0. RR pointer = 0. Tag pipe cleared. Takes effect immediately, no clock needed.
- Grant: combinational from req_vld, the RR pointer and hold.
  - Search starts at index ptr and wraps modulo N; the first i with req_vld[i] wins.
  - req_rdy = one-hot of the winner; all zero if hold=1 or no request.
  - req_rdy may depend on req_vld; requesters must not make req_vld depend on req_rdy.
- Issue register: on a handshake with winner g, next cycle rnd_i_vld=1 and rnd_i_data=req_data[g]. Otherwise rnd_i_vld=0 and rnd_i_data holds its value. At most one issue per cycle, so full throughput is 1 sample/clk.
- RR pointer: after a handshake with winner g, ptr ← (g+1) mod N. With no handshake, ptr is unchanged. Continuous requests from all N are served g=0,1,..,N-1,0,...
- Tag pipe: a shift register of depth RND_LAT, each entry {vld, id[clog2(N)]}.
  - Stage 0 loads {rnd_i_vld, id of the issued sample} each cycle.
  - The tail entry is aligned with rnd_o_vld.
- Response: on rnd_o_vld=1 with tail.vld=1, next cycle rsp_data=rnd_o_data and rsp_vld=onehot(tail.id). Otherwise rsp_vld=0 and rsp_data holds.
- Latency: handshake edge → rnd_i_vld = 1 cycle; handshake → rsp_vld = RND_LAT+2 cycles.
- Mismatch cases:
  - rnd_o_vld=1 with tail.vld=0: result dropped, no rsp_vld.
  - tail.vld=1 with rnd_o_vld=0: tag discarded.
- hold asserted mid-stream: issue stops the same cycle. Already-issued samples return normally. busy falls after the last rsp_vld.
- Reset mid-operation: every in-flight tag is lost and no rsp_vld is produced for it. The round unit is reset by the same system reset.
- Widths: data passes through unchanged. No sign or width arithmetic in this block.

Optional Feature:
- Macro ROUND_SHARE_ARB_LAT_CHK_EN adds output `lat_err` (1 bit, reset 0).
- Defined:
  - lat_err sets sticky when rnd_o_vld ≠ tail.vld in any cycle.
  - It clears only on rst.
  - Each set emits a $error with cycle time in simulation.
- Undefined: the port and the logic are absent. Mismatches are handled silently as described in Behaviour.

Test Plan:
- Bench setup: round model = arithmetic shift right by W_IN−W_OUT with round-half-up, latency RND_LAT=2.
- Single request: req_vld[1]=1, req_data[1]=33'd65535 for one handshake → rnd_i_vld at +1 with rnd_i_data=65535; rsp_vld=4'b0010 at +4 with rsp_data=32768; busy high +1..+4.
- All four requesting continuously with distinct data (0x100·(i+1)) for 8 cycles → grants 0,1,2,3,0,1,2,3. rsp_vld pulses in the same order, each with the matching rounded value, with no gaps.
- Contention plus pointer: ptr=2 and req_vld=4'b1011 → grant 3; the next cycle with the same vld → grant 0.
- Hold: assert hold after 2 issues while 2 are in flight → req_rdy=0, both responses still arrive, busy deasserts after the second rsp_vld.
- Reset mid-flight: rst pulse 1 cycle after an issue → all outputs 0 immediately, no rsp_vld afterwards. With LAT_CHK_EN, inject a stray rnd_o_vld → lat_err=1 and stays 1 until rst.
